apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
- Shares a single APB master port between NB_REQ on-chip requesters (debug bridge, DMA, core peripheral path, etc.).
- The master port drives the slave port of the APB node.
- Round-robin arbitration, one transaction in flight at a time.
- Generates the APB SETUP/ACCESS sequence and returns read data and error per requester.

Parameters:
- NB_REQ, 2, number of requesters (>=2).
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 256, ACCESS wait-cycle limit (used only with APB_ARB_TIMEOUT_EN; >=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NB_REQ  per-requester transfer request
- req_we_i  in  NB_REQ  1=write, 0=read
- req_addr_i  in  [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]  per-requester address
- req_wdata_i  in  [NB_REQ-1:0][APB_DATA_WIDTH-1:0]  per-requester write data
- gnt_o  out  NB_REQ  one-hot grant pulse; payload sampled this cycle
- rsp_valid_o  out  NB_REQ  one-hot response pulse
- rsp_rdata_o  out  APB_DATA_WIDTH  read data, valid with rsp_valid_o
- rsp_err_o  out  1  error flag, valid with rsp_valid_o
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  APB_DATA_WIDTH  APB write data
- prdata_i  in  APB_DATA_WIDTH  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset values (async, rst_ni=0):
  - state=IDLE, rr pointer=0.
  - psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0.
  - paddr_o, pwdata_o, rsp_rdata_o = 0.
  - gnt_o=0 (combinational, forced 0 outside IDLE).
- All APB outputs and rsp_* are registered. gnt_o is combinational from IDLE state and req_i.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any unmasked req_i is high, the winner is the first requester at or after the rr pointer, wrapping NB_REQ-1 -> 0.
  - gnt_o[winner]=1 this cycle.
  - Latch addr/we/wdata into paddr_o/pwrite_o/pwdata_o; psel_o<=1.
  - rr pointer <= (winner+1) mod NB_REQ; record owner; next state SETUP.
  - If no request, stay in IDLE with no grant.
- SETUP: psel=1, penable=0 for exactly one cycle, then penable_o<=1 and go to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - On the cycle pready_i=1:
    - Next cycle: rsp_valid_o[owner]=1 for one cycle, rsp_rdata_o=prdata_i (0 for writes), rsp_err_o=pslverr_i.
    - psel_o, penable_o <= 0; state <= IDLE.
- Latency:
  - Grant at cycle N; SETUP N+1; ACCESS N+2.
  - With zero wait states, the response pulse is at N+3 (the same cycle as the next IDLE).
  - A new grant is possible at N+3. Minimum issue interval is 3 cycles.
- Requester rules:
  - Hold req_i and payload stable until gnt_o.
  - Deasserting req_i before grant cancels the request with no side effect.
  - req_i may stay high after grant, but is masked for the owner until its rsp_valid_o cycle. A new request is granted at the earliest in that cycle, subject to rr order.
- Simultaneous requests: strict rotation. With all requesters high continuously, grants go 0,1,...,NB_REQ-1,0,...
- pready_i or pslverr_i outside ACCESS: ignored. pslverr_i is sampled only with pready_i.
- Reset mid-transaction: immediate return to reset values. No rsp_valid_o is generated for the aborted transfer.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer is aborted.
  - Next cycle: rsp_valid_o[owner]=1, rsp_err_o=1, rsp_rdata_o=0; psel_o/penable_o=0; state IDLE.
  - pready_i arriving in the abort cycle itself takes priority (normal completion).
- Without the macro: no counter logic; ACCESS waits indefinitely for pready_i.

Decomposition:
- Package apb_arb_pkg:
  - State enum typedef (IDLE/SETUP/ACCESS, 2-bit).
  - Default TIMEOUT_CYCLES constant.
  - Index-width function (clog2 of NB_REQ, min 1).
- Sub-module rr_prio_sel (parameter NB_REQ):
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner, winner index, any_valid.
  - Purely combinational.

Test Plan:
- Write, zero wait: req_i=01, addr 0x1A10_0004, wdata 0xDEAD_BEEF, pready tied 1 -> gnt_o=01 at N; psel only at N+1; psel+penable at N+2; rsp_valid_o=01 with err=0 at N+3; paddr/pwdata stable N+1..N+2.
- Contention: req_i=11 held for 4 transfers -> grant order 0,1,0,1; each owner's req masked until its rsp_valid_o.
- Read with 3 wait states: prdata=0x0000_00A5 presented with pready at the 4th ACCESS cycle -> rsp_rdata_o=0xA5 one cycle later; penable high for exactly 4 cycles.
- Slave error: pslverr_i=1 with pready_i on a write from requester 1 -> rsp_valid_o=10, rsp_err_o=1.
- Timeout (macro on, TIMEOUT_CYCLES=8, pready stuck 0) -> abort after 8 wait cycles; rsp_err_o=1, rdata=0; next request granted normally.
- Reset asserted during ACCESS -> all outputs 0 asynchronously, no rsp_valid_o; after release, a pending req_i=10 is granted to requester 1 first (pointer=0, requester 0 idle).

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB round-robin arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 256;

    // Width of a requester index; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Round-robin priority selector: picks the first request at or after the
// pointer, wrapping from NB_REQ-1 back to 0. Purely combinational.
module rr_prio_sel
    import apb_arb_pkg::*;
#(
    parameter int unsigned NB_REQ = 2,
    parameter int unsigned IW     = idx_width(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NB_REQ-1:0] onehot_o,
    output logic [IW-1:0]     idx_o,
    output logic              valid_o
);

    logic [IW-1:0] cand;

    // Scan requesters in rotation order starting at the pointer.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            cand = IW'((32'(ptr_i) + k) % NB_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                onehot_o[cand] = 1'b1;
                idx_o          = cand;
            end
        end
    end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB master port between NB_REQ requesters.
// Optional ACCESS wait-state timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NB_REQ         = 2,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NB_REQ-1:0]                      req_i,
    input  logic [NB_REQ-1:0]                      req_we_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NB_REQ-1:0]                      gnt_o,
    output logic [NB_REQ-1:0]                      rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]              rsp_rdata_o,
    output logic                                   rsp_err_o,
    output logic                                   psel_o,
    output logic                                   penable_o,
    output logic                                   pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]              paddr_o,
    output logic [APB_DATA_WIDTH-1:0]              pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]              prdata_i,
    input  logic                                   pready_i,
    input  logic                                   pslverr_i
);

    localparam int unsigned IW = idx_width(NB_REQ);

    apb_state_e                state_q;
    logic [IW-1:0]             ptr_q;
    logic [IW-1:0]             ptr_d;
    logic [NB_REQ-1:0]         owner_q;
    logic [NB_REQ-1:0]         rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      pwrite_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;

    logic [NB_REQ-1:0]         win_oh;
    logic [IW-1:0]             win_idx;
    logic                      win_vld;

    // Arbitration only happens in IDLE, so an owner's held request is
    // naturally masked until the cycle its response is returned.
    rr_prio_sel #(
        .NB_REQ (NB_REQ),
        .IW     (IW)
    ) u_sel (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .valid_o  (win_vld)
    );

    // Pointer advances past the winner, wrapping at NB_REQ-1.
    always_comb begin
        ptr_d = (win_idx == IW'(NB_REQ - 1)) ? '0 : win_idx + IW'(1);
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        paddr_q  <= req_addr_i[win_idx];
                        pwrite_q <= req_we_i[win_idx];
                        pwdata_q <= req_wdata_i[win_idx];
                        psel_q   <= 1'b1;
                        ptr_q    <= ptr_d;
                        owner_q  <= win_oh;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_q    <= '0;
`endif
                end
                ACCESS: begin
                    if (pready_i) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata_i;
                        rsp_err_q   <= pslverr_i;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    // The cycle that would bring the count to the limit aborts.
                    else if (wait_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q <= owner_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is combinational and only ever issued from IDLE out of reset.
    always_comb begin
        gnt_o = (rst_ni && state_q == IDLE) ? win_oh : '0;
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter (NB_REQ=2).
// Timeout scenario is exercised when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_rr_arbiter;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req = '0;
    logic [1:0]        req_we = '0;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              psel, penable, pwrite;
    logic [31:0]       paddr, pwdata;
    logic [31:0]       prdata = '0;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;

    int total = 0;
    int bad   = 0;

    apb_rr_arbiter #(
        .NB_REQ         (2),
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .paddr_o     (paddr),
        .pwdata_o    (pwdata),
        .prdata_i    (prdata),
        .pready_i    (pready),
        .pslverr_i   (pslverr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_gnt", gnt, 0);
        rst_n = 1'b1;

        // ---------------- write, zero wait ----------------
        pready = 1'b1;
        req = 2'b01; req_we = 2'b01;
        req_addr[0] = 32'h1A10_0004; req_wdata[0] = 32'hDEAD_BEEF;
        #1;
        check("wr_gnt", gnt, 2'b01);
        tick();                                     // N+1 SETUP
        req = 2'b00;
        check("wr_setup_psel", psel, 1);
        check("wr_setup_pen", penable, 0);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_paddr", paddr, 32'h1A10_0004);
        check("wr_setup_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_setup_gnt", gnt, 0);
        tick();                                     // N+2 ACCESS
        check("wr_acc_psel", psel, 1);
        check("wr_acc_pen", penable, 1);
        check("wr_acc_paddr", paddr, 32'h1A10_0004);
        check("wr_acc_pwdata", pwdata, 32'hDEAD_BEEF);
        check("wr_acc_rsp", rsp_valid, 0);
        tick();                                     // N+3 response
        check("wr_rsp_valid", rsp_valid, 2'b01);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_rsp_psel", psel, 0);
        check("wr_rsp_pen", penable, 0);
        tick();
        check("wr_rsp_pulse", rsp_valid, 0);

        // pready/pslverr outside ACCESS are ignored
        pslverr = 1'b1;
        tick();
        check("idle_ignore_rsp", rsp_valid, 0);
        check("idle_ignore_psel", psel, 0);
        pslverr = 1'b0;

        // ---------------- contention: 0,1,0,1 from pointer 0 ----------------
        do_reset();
        prdata = 32'h0000_1234;
        req_we = 2'b00;
        req = 2'b11;
        begin
            logic [1:0] order [4];
            order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
            for (int i = 0; i < 4; i++) begin
                #1;
                check($sformatf("cont_gnt%0d", i), gnt, order[i]);
                if (i > 0) begin
                    check($sformatf("cont_rsp%0d", i - 1), rsp_valid, order[i - 1]);
                    check($sformatf("cont_rdata%0d", i - 1), rsp_rdata, 32'h0000_1234);
                end
                tick();
                if (i == 3) req = 2'b00;
                check($sformatf("cont_mask_setup%0d", i), gnt, 0);
                tick();
                check($sformatf("cont_mask_acc%0d", i), gnt, 0);
                tick();
            end
            check("cont_rsp3", rsp_valid, 2'b10);
            check("cont_end_gnt", gnt, 0);
        end
        tick();

        // ---------------- read, 3 wait states (pointer at 0) ----------------
        pready = 1'b0;
        prdata = 32'h0;
        req = 2'b01; req_we = 2'b00; req_addr[0] = 32'h0000_0040;
        #1;
        check("rd_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        check("rd_setup_pen", penable, 0);
        tick();
        begin
            int pen_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                if (penable === 1'b1) pen_cnt++;
                check($sformatf("rd_wait_rsp%0d", k), rsp_valid, 0);
                if (k == 3) begin
                    pready = 1'b1;
                    prdata = 32'h0000_00A5;
                end
                tick();
            end
            check("rd_pen_cycles", 64'(pen_cnt), 4);
        end
        check("rd_rsp_valid", rsp_valid, 2'b01);
        check("rd_rsp_rdata", rsp_rdata, 32'h0000_00A5);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_pen_low", penable, 0);
        tick();

        // ---------------- slave error, write from requester 1 ----------------
        pslverr = 1'b1;
        req = 2'b10; req_we = 2'b10;
        req_addr[1] = 32'h2000_0010; req_wdata[1] = 32'h0BAD_F00D;
        #1;
        check("err_gnt", gnt, 2'b10);
        tick();
        req = 2'b00;
        check("err_paddr", paddr, 32'h2000_0010);
        tick();
        tick();
        check("err_rsp_valid", rsp_valid, 2'b10);
        check("err_rsp_err", rsp_err, 1);
        pslverr = 1'b0;
        tick();

        // ---------------- reset during ACCESS ----------------
        pready = 1'b0;
        req = 2'b01; req_we = 2'b00; req_addr[0] = 32'h0000_0080;
        #1;
        check("rstacc_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        tick();
        check("rstacc_in_access", penable, 1);
        req = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstacc_psel", psel, 0);
        check("rstacc_pen", penable, 0);
        check("rstacc_paddr", paddr, 0);
        check("rstacc_gnt", gnt, 0);
        pready = 1'b1;
        tick();
        check("rstacc_no_rsp", rsp_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rstacc_rel_gnt", gnt, 2'b10);
        tick();
        req = 2'b00;
        check("rstacc_no_rsp2", rsp_valid, 0);
        tick();
        tick();
        check("rstacc_rsp", rsp_valid, 2'b10);
        tick();

`ifdef APB_ARB_TIMEOUT_EN
        // ---------------- timeout, limit 8 ----------------
        do_reset();
        pready = 1'b0;
        prdata = 32'hFFFF_0000;
        req = 2'b01; req_we = 2'b00;
        #1;
        check("to_gnt", gnt, 2'b01);
        tick();
        req = 2'b00;
        tick();
        begin
            int pen_cnt = 0;
            for (int k = 0; k < 8; k++) begin
                if (penable === 1'b1) pen_cnt++;
                check($sformatf("to_wait_rsp%0d", k), rsp_valid, 0);
                tick();
            end
            check("to_pen_cycles", 64'(pen_cnt), 8);
        end
        check("to_rsp_valid", rsp_valid, 2'b01);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", psel, 0);
        pready = 1'b1;
        prdata = 32'h0000_0077;
        req = 2'b10;
        #1;
        check("to_next_gnt", gnt, 2'b10);
        tick();
        req = 2'b00;
        tick();
        tick();
        check("to_next_rsp", rsp_valid, 2'b10);
        check("to_next_err", rsp_err, 0);
        check("to_next_rdata", rsp_rdata, 32'h0000_0077);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
